// File: rtl/tile_csr_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tile_csr_initiator
// Purpose  : CSR bus initiator for one compute tile. Host commands are queued
//            in a small FIFO and issued one at a time on the tile CSR port.
//            Every command produces exactly one response, which carries either
//            the read data or a timeout error.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            cmd_valid/ready/write/addr/wdata - host command channel (queued)
//            rsp_valid/ready/rdata/error      - host response channel
//            csr_valid/write/addr/wdata       - request to tile (registered)
//            csr_rdata/csr_ready              - tile completion and read data
//            busy, cmd_level, txn_count, timeout_count - status
// Revision : 1.0 - initial release
// ============================================================================
module tile_csr_initiator #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  // host command channel
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [DATA_WIDTH-1:0]        cmd_wdata,
  // host response channel
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_error,
  // tile CSR port
  output logic                         csr_valid,
  output logic                         csr_write,
  output logic [ADDR_WIDTH-1:0]        csr_addr,
  output logic [DATA_WIDTH-1:0]        csr_wdata,
  input  logic [DATA_WIDTH-1:0]        csr_rdata,
  input  logic                         csr_ready,
  // status
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level,
  output logic [15:0]                  txn_count,
  output logic [7:0]                   timeout_count
);

  localparam int c_ptr_w   = $clog2(CMD_DEPTH);
  localparam int c_lvl_w   = c_ptr_w + 1;
  localparam int c_entry_w = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int c_wait_w  = $clog2(TIMEOUT_CYCLES);

  localparam logic [c_lvl_w-1:0]  c_depth     = c_lvl_w'(CMD_DEPTH);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [c_entry_w-1:0] r_mem [CMD_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifo_empty;
  logic [c_entry_w-1:0] w_head;

  // cmd_ready depends only on the registered level, so there is no
  // combinational path from cmd_valid back to cmd_ready.
  assign cmd_ready    = (r_level != c_depth);
  assign w_push       = cmd_valid && cmd_ready;
  assign w_fifo_empty = (r_level == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign cmd_level    = r_level;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transaction FSM
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_next;

  logic   w_complete;   // tile answered this cycle
  logic   w_timeout;    // wait budget exhausted this cycle
  logic   w_wait_inc;
  logic   w_rsp_taken;

  logic [c_wait_w-1:0] r_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    w_wait_inc   = 1'b0;
    w_rsp_taken  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A ready on the final wait cycle still counts as a completion.
        if (csr_ready) begin
          w_complete   = 1'b1;
          w_state_next = S_RESP;
        end else if (r_wait == c_wait_last) begin
          w_timeout    = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_wait_inc   = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_taken = 1'b1;
          // Chain straight into the next request to sustain one
          // transaction every two cycles.
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_ISSUE;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // CSR request registers and wait counter
  // --------------------------------------------------------------------------
  logic                  r_csr_valid;
  logic                  r_csr_write;
  logic [ADDR_WIDTH-1:0] r_csr_addr;
  logic [DATA_WIDTH-1:0] r_csr_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csr_valid <= 1'b0;
      r_csr_write <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;
      r_wait      <= '0;
    end else begin
      if (w_pop) begin
        r_csr_valid <= 1'b1;
        r_csr_write <= w_head[c_entry_w-1];
        r_csr_addr  <= w_head[DATA_WIDTH +: ADDR_WIDTH];
        r_csr_wdata <= w_head[DATA_WIDTH-1:0];
        r_wait      <= '0;
      end else if (w_complete || w_timeout) begin
        // Address/data are left as-is; only csr_valid qualifies them.
        r_csr_valid <= 1'b0;
      end else if (w_wait_inc) begin
        r_wait      <= r_wait + c_wait_w'(1);
      end
    end
  end

  assign csr_valid = r_csr_valid;
  assign csr_write = r_csr_write;
  assign csr_addr  = r_csr_addr;
  assign csr_wdata = r_csr_wdata;

  // --------------------------------------------------------------------------
  // Response registers and statistics
  // --------------------------------------------------------------------------
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_error;
  logic [15:0]           r_txn_count;
  logic [7:0]            r_timeout_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid     <= 1'b0;
      r_rsp_rdata     <= '0;
      r_rsp_error     <= 1'b0;
      r_txn_count     <= '0;
      r_timeout_count <= '0;
    end else begin
      if (w_complete) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= r_csr_write ? '0 : csr_rdata;
        r_rsp_error <= 1'b0;
        r_txn_count <= r_txn_count + 16'd1;
      end else if (w_timeout) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_error <= 1'b1;
        r_txn_count <= r_txn_count + 16'd1;
        if (r_timeout_count != 8'hFF) begin
          r_timeout_count <= r_timeout_count + 8'd1;
        end
      end else if (w_rsp_taken) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_error     = r_rsp_error;
  assign txn_count     = r_txn_count;
  assign timeout_count = r_timeout_count;

  assign busy = (r_state != S_IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire
